// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives the PC register, issues instruction memory
// reads and holds one fetched instruction for the downstream stage.
//
//   state | meaning
//   IDLE  | just out of reset, no request, branches ignored
//   FETCH | request at pc_in whenever the output slot is free
//   KILL  | re-issue the address abandoned by a branch and drop its data
module fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int PC_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [ADDR_W-1:0] imem_rdata,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              stall,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc
);

    typedef enum logic [1:0] {IDLE, FETCH, KILL} state_t;

    localparam logic [ADDR_W-1:0] STEP  = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN = ~(ADDR_W'(3));

    state_t            state;
    logic              pending;
    logic [ADDR_W-1:0] kill_addr;
    logic              slot_free;
    logic              branch_ok;
    logic              fetch_ack;
    logic [ADDR_W-1:0] pc_seq;

    // Request generation and PC steering; pending keeps a started request
    // asserted until its ack even if the output slot becomes occupied.
    always_comb begin
        slot_free = !instr_valid || !stall;
        imem_req  = 1'b0;
        imem_addr = pc_in;
        case (state)
            FETCH: imem_req = slot_free || pending;
            KILL: begin
                imem_req  = 1'b1;
                imem_addr = kill_addr;
            end
            default: imem_req = 1'b0;
        endcase
        if (reset) imem_req = 1'b0;

        branch_ok = branch_taken && (state != IDLE) && !reset;
        fetch_ack = (state == FETCH) && imem_req && imem_ack;
        pc_en     = branch_ok || fetch_ack;
        pc_seq    = pc_in + STEP;
        if (reset)
            pc_next = '0;
        else if (branch_ok)
            pc_next = branch_target & ALIGN;
        else
            pc_next = pc_seq & ALIGN;
    end

    // FSM plus the instruction holding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            kill_addr   <= '0;
            instr_valid <= 1'b0;
            instr       <= '0;
            instr_pc    <= '0;
        end else begin
            case (state)
                IDLE: state <= FETCH;
                FETCH: begin
                    if (branch_taken) begin
                        instr_valid <= 1'b0;
                        pending     <= 1'b0;
                        // An unanswered request must still be retired in KILL.
                        if (imem_req && !imem_ack) begin
                            kill_addr <= imem_addr;
                            state     <= KILL;
                        end
                    end else if (fetch_ack) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc_in;
                        instr_valid <= 1'b1;
                        pending     <= 1'b0;
                    end else begin
                        if (instr_valid && !stall) instr_valid <= 1'b0;
                        pending <= imem_req;
                    end
                end
                KILL: begin
                    instr_valid <= 1'b0;
                    pending     <= 1'b0;
                    if (imem_ack) state <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle vector table, asynchronous reset sequence and
// a streaming run against a wait-state memory model with a scoreboard.
module tb_fetch_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_in;
    logic [AW-1:0] pc_next;
    logic          pc_en;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [AW-1:0] imem_rdata;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          stall;
    logic          instr_valid;
    logic [AW-1:0] instr;
    logic [AW-1:0] instr_pc;

    fetch_unit #(.ADDR_W(AW), .PC_STEP(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .pc_next      (pc_next),
        .pc_en        (pc_en),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .stall        (stall),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rdata;
        logic        br;
        logic [31:0] tgt;
        logic        stl;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_en;
        logic [31:0] e_next;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t        vt[18];
    logic [63:0] sb_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hA5A5_0000;
    endfunction

    initial begin
        logic [31:0] exp_addr;
        logic [63:0] ent;
        int          wcnt;
        int          wtarget;
        int          n_acks;

        vt[0]  = '{32'h0,        1'b0, 32'h0,    1'b1, 32'h200, 1'b0, 1'b0, 32'h0,        1'b0, 32'h4,   1'b0, 32'h0,  32'h0};
        vt[1]  = '{32'h0,        1'b1, 32'h11,   1'b0, 32'h0,   1'b0, 1'b1, 32'h0,        1'b1, 32'h4,   1'b1, 32'h11, 32'h0};
        vt[2]  = '{32'h4,        1'b1, 32'h22,   1'b0, 32'h0,   1'b0, 1'b1, 32'h4,        1'b1, 32'h8,   1'b1, 32'h22, 32'h4};
        vt[3]  = '{32'h8,        1'b1, 32'h33,   1'b0, 32'h0,   1'b0, 1'b1, 32'h8,        1'b1, 32'hC,   1'b1, 32'h33, 32'h8};
        vt[4]  = '{32'hC,        1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b0, 32'hC,        1'b0, 32'h10,  1'b1, 32'h33, 32'h8};
        vt[5]  = '{32'hC,        1'b1, 32'hEE,   1'b0, 32'h0,   1'b1, 1'b0, 32'hC,        1'b0, 32'h10,  1'b1, 32'h33, 32'h8};
        vt[6]  = '{32'hC,        1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b1, 32'hC,        1'b0, 32'h10,  1'b0, 32'h33, 32'h8};
        vt[7]  = '{32'hC,        1'b0, 32'h0,    1'b0, 32'h0,   1'b1, 1'b1, 32'hC,        1'b0, 32'h10,  1'b0, 32'h33, 32'h8};
        vt[8]  = '{32'hC,        1'b1, 32'h44,   1'b0, 32'h0,   1'b0, 1'b1, 32'hC,        1'b1, 32'h10,  1'b1, 32'h44, 32'hC};
        vt[9]  = '{32'h10,       1'b0, 32'h0,    1'b1, 32'h103, 1'b1, 1'b0, 32'h10,       1'b1, 32'h100, 1'b0, 32'h44, 32'hC};
        vt[10] = '{32'h100,      1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b1, 32'h100,      1'b0, 32'h104, 1'b0, 32'h44, 32'hC};
        vt[11] = '{32'h100,      1'b0, 32'h0,    1'b1, 32'h200, 1'b0, 1'b1, 32'h100,      1'b1, 32'h200, 1'b0, 32'h44, 32'hC};
        vt[12] = '{32'h200,      1'b0, 32'h0,    1'b1, 32'h300, 1'b0, 1'b1, 32'h100,      1'b1, 32'h300, 1'b0, 32'h44, 32'hC};
        vt[13] = '{32'h300,      1'b1, 32'hDEAD, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100,      1'b0, 32'h304, 1'b0, 32'h44, 32'hC};
        vt[14] = '{32'h300,      1'b1, 32'h55,   1'b1, 32'h400, 1'b0, 1'b1, 32'h300,      1'b1, 32'h400, 1'b0, 32'h44, 32'hC};
        vt[15] = '{32'h400,      1'b1, 32'h66,   1'b0, 32'h0,   1'b0, 1'b1, 32'h400,      1'b1, 32'h404, 1'b1, 32'h66, 32'h400};
        vt[16] = '{32'hFFFFFFFC, 1'b1, 32'h77,   1'b0, 32'h0,   1'b0, 1'b1, 32'hFFFFFFFC, 1'b1, 32'h0,   1'b1, 32'h77, 32'hFFFFFFFC};
        vt[17] = '{32'h0,        1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 1'b1, 32'h0,        1'b0, 32'h4,   1'b0, 32'h77, 32'hFFFFFFFC};

        // Reset state, with a nonzero pc_in so a non-gated pc_next would show.
        reset = 1'b1; pc_in = 32'h40; imem_ack = 1'b0; imem_rdata = '0;
        branch_taken = 1'b0; branch_target = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req",   {31'd0, imem_req},    32'd0);
        chk("rst.en",    {31'd0, pc_en},       32'd0);
        chk("rst.valid", {31'd0, instr_valid}, 32'd0);
        chk("rst.next",  pc_next,              32'd0);
        chk("rst.instr", instr,                32'd0);
        chk("rst.ipc",   instr_pc,             32'd0);
        reset = 1'b0;

        // Cycle-accurate vector table.
        for (int i = 0; i < 18; i++) begin
            pc_in = vt[i].pc; imem_ack = vt[i].ack; imem_rdata = vt[i].rdata;
            branch_taken = vt[i].br; branch_target = vt[i].tgt; stall = vt[i].stl;
            #1;
            chk($sformatf("v%0d.req", i), {31'd0, imem_req}, {31'd0, vt[i].e_req});
            if (vt[i].e_req) chk($sformatf("v%0d.addr", i), imem_addr, vt[i].e_addr);
            chk($sformatf("v%0d.en", i),   {31'd0, pc_en}, {31'd0, vt[i].e_en});
            chk($sformatf("v%0d.next", i), pc_next, vt[i].e_next);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.valid", i), {31'd0, instr_valid}, {31'd0, vt[i].e_valid});
            chk($sformatf("v%0d.instr", i), instr,    vt[i].e_instr);
            chk($sformatf("v%0d.ipc", i),   instr_pc, vt[i].e_ipc);
        end

        // Asynchronous reset while a request is outstanding.
        pc_in = 32'h0; imem_ack = 1'b1; imem_rdata = 32'h88; branch_taken = 1'b0; stall = 1'b0;
        @(posedge clk);
        #1;
        chk("ar.valid0", {31'd0, instr_valid}, 32'd1);
        pc_in = 32'h4; imem_ack = 1'b0; imem_rdata = '0;
        #1;
        chk("ar.req0", {31'd0, imem_req}, 32'd1);
        reset = 1'b1;
        #1;
        chk("ar.req",   {31'd0, imem_req},    32'd0);
        chk("ar.valid", {31'd0, instr_valid}, 32'd0);
        chk("ar.en",    {31'd0, pc_en},       32'd0);
        chk("ar.next",  pc_next,              32'd0);
        chk("ar.instr", instr,                32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h99;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("ar.idle_req", {31'd0, imem_req}, 32'd0);
        chk("ar.idle_en",  {31'd0, pc_en},    32'd0);
        @(posedge clk);
        #1;
        chk("ar.late_ack", {31'd0, instr_valid}, 32'd0);

        // Streaming with wait-state memory, random stalls and a scoreboard.
        pc_in = 32'h0; imem_ack = 1'b0; imem_rdata = '0;
        exp_addr = 32'h0; wcnt = 0; wtarget = 0; n_acks = 0;
        for (int c = 0; c < 120; c++) begin
            stall = ($urandom_range(0, 3) == 0);
            imem_ack = 1'b0; imem_rdata = '0;
            #1;
            if (imem_req) begin
                chk($sformatf("s%0d.addr", c), imem_addr, exp_addr);
                if (wcnt == wtarget) begin
                    imem_ack = 1'b1;
                    imem_rdata = mem_word(exp_addr);
                end else begin
                    wcnt++;
                end
            end
            #1;
            chk($sformatf("s%0d.en", c), {31'd0, pc_en}, {31'd0, imem_ack});
            if (imem_ack) chk($sformatf("s%0d.next", c), pc_next, exp_addr + 32'd4);
            if (instr_valid && !stall) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL s%0d.sb: got unexpected instr %h expected none", c, instr);
                end else begin
                    ent = sb_q.pop_front();
                    chk($sformatf("s%0d.instr", c), instr,    ent[63:32]);
                    chk($sformatf("s%0d.ipc", c),   instr_pc, ent[31:0]);
                end
            end
            if (imem_ack) begin
                sb_q.push_back({mem_word(exp_addr), exp_addr});
                exp_addr = exp_addr + 32'd4;
                n_acks++;
                wcnt = 0;
                wtarget = (n_acks == 3) ? 3 : int'($urandom_range(0, 3));
            end
            @(posedge clk);
            #1;
            if (imem_ack) pc_in = exp_addr;
        end
        chk("s.progress", {31'd0, (n_acks > 20)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
